// File: rtl/booth_multiplier.sv
// Sequential 32x32 signed Booth multiplier with start/done/clear handshake and a 64-bit product.
// Build option RADIX4_EN selects radix-4 recoding (16 steps) instead of radix-2 (32 steps).
module booth_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  input  logic        op_start,
  input  logic        op_clear,
  output logic        op_done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

`ifdef RADIX4_EN
  localparam logic [4:0] LAST_STEP = 5'd15;
`else
  localparam logic [4:0] LAST_STEP = 5'd31;
`endif

  state_t      state_q;
  logic [32:0] a_q;
  logic [31:0] hi_q, lo_q;
  logic        qm1_q;
  logic [4:0]  count_q;
  logic        done_q;

  logic [31:0] hi_d, lo_d;
  logic        qm1_d;

`ifdef RADIX4_EN
  // 34-bit sum: the upper half plus up to +/-2A needs two guard bits.
  logic [33:0] sum4;
  logic [33:0] hi_ext, a_ext, a2_ext;

  always_comb begin
    hi_ext = {{2{hi_q[31]}}, hi_q};
    a_ext  = {a_q[32], a_q};
    a2_ext = {a_q, 1'b0};
    sum4   = hi_ext;
    case ({lo_q[1:0], qm1_q})
      3'b001, 3'b010: sum4 = hi_ext + a_ext;
      3'b011:         sum4 = hi_ext + a2_ext;
      3'b100:         sum4 = hi_ext - a2_ext;
      3'b101, 3'b110: sum4 = hi_ext - a_ext;
      default:        sum4 = hi_ext;
    endcase
    hi_d  = sum4[33:2];
    lo_d  = {sum4[1:0], lo_q[31:2]};
    qm1_d = lo_q[1];
  end
`else
  // 33-bit sum keeps A = -2^31 from overflowing the upper half.
  logic [32:0] sum2;
  logic [32:0] hi_ext;

  always_comb begin
    hi_ext = {hi_q[31], hi_q};
    sum2   = hi_ext;
    case ({lo_q[0], qm1_q})
      2'b01:   sum2 = hi_ext + a_q;
      2'b10:   sum2 = hi_ext - a_q;
      default: sum2 = hi_ext;
    endcase
    hi_d  = sum2[32:1];
    lo_d  = {sum2[0], lo_q[31:1]};
    qm1_d = lo_q[0];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else if (op_clear) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_start) begin
            a_q     <= {multiplicand[31], multiplicand};
            hi_q    <= '0;
            lo_q    <= multiplier;
            qm1_q   <= 1'b0;
            count_q <= '0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          qm1_q   <= qm1_d;
          count_q <= count_q + 5'd1;
          if (count_q == LAST_STEP) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign op_done = done_q;
  assign result  = {hi_q, lo_q};

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed corners, abort/reset cases and random pairs
// compared against a 64-bit signed arithmetic reference.
module tb_booth_multiplier;

`ifdef RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] multiplicand, multiplier;
  logic        op_start, op_clear;
  logic        op_done;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_multiplier dut (
    .clk          (clk),
    .reset        (reset),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .op_done      (op_done),
    .result       (result)
  );

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    multiplicand = a;
    multiplier   = b;
    op_start     = 1'b1;
    tick();
    op_start     = 1'b0;
  endtask

  // n0 = edges already elapsed since the accepting edge
  task automatic wait_done(input string tag, input int n0, input logic [63:0] exp, input bit verbose);
    int n;
    n = n0;
    while (op_done !== 1'b1 && n < LAT + 8) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    check({tag, "_result"}, result, exp);
    if (verbose)
      $display("op %s: latency=%0d result=%h expected=%h", tag, n, result, exp);
  endtask

  task automatic clear_op(input string tag);
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    check({tag, "_clr_done"}, 64'(op_done), 64'd0);
    check({tag, "_clr_result"}, result, 64'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input bit verbose);
    start_op(a, b);
    wait_done(tag, 0, ref_prod(a, b), verbose);
  endtask

  task automatic watch_idle(input string tag);
    bit seen;
    seen = 1'b0;
    repeat (LAT + 2) begin
      tick();
      if (op_done === 1'b1) seen = 1'b1;
    end
    check({tag, "_no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset        = 1'b1;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #2;
    check("reset_done", 64'(op_done), 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 11 x -11, held until cleared
    run("11x-11", 32'd11, -32'sd11, 1'b1);
    check("11x-11_const", result, 64'hFFFF_FFFF_FFFF_FF87);
    repeat (5) tick();
    check("11x-11_hold_done", 64'(op_done), 64'd1);
    check("11x-11_hold_res", result, 64'hFFFF_FFFF_FFFF_FF87);
    clear_op("11x-11");

    // start right after a clear
    run("6x6", 32'd6, 32'd6, 1'b1);
    check("6x6_const", result, 64'h0000_0000_0000_0024);
    clear_op("6x6");

    run("min_x_min", 32'h8000_0000, 32'h8000_0000, 1'b1);
    check("min_x_min_const", result, 64'h4000_0000_0000_0000);
    clear_op("min_x_min");
    run("m1_x_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("m1_x_m1_const", result, 64'd1);
    clear_op("m1_x_m1");
    run("max_x_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    check("max_x_min_const", result, 64'hC000_0000_8000_0000);
    clear_op("max_x_min");
    run("a_x_0", 32'hDEAD_BEEF, 32'd0, 1'b1);
    clear_op("a_x_0");

    // op_start held high: one operation only, result held in DONE
    multiplicand = 32'd1234;
    multiplier   = -32'sd77;
    op_start     = 1'b1;
    tick();
    wait_done("held_start", 0, ref_prod(32'd1234, -32'sd77), 1'b1);
    repeat (3) tick();
    check("held_start_hold", result, ref_prod(32'd1234, -32'sd77));
    op_start = 1'b0;
    clear_op("held_start");

    // operands change and op_start pulses during EXEC
    start_op(32'd7, 32'd9);
    repeat (3) tick();
    multiplicand = 32'hFFFF_0000;
    multiplier   = 32'h1234_5678;
    op_start     = 1'b1;
    tick();
    op_start     = 1'b0;
    wait_done("midop_change", 4, 64'd63, 1'b1);
    clear_op("midop_change");

    // abort at step 10, then a fresh operation
    start_op(32'h0000_1111, 32'h0000_2222);
    repeat (9) tick();
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    check("abort_result", result, 64'd0);
    check("abort_done", 64'(op_done), 64'd0);
    watch_idle("abort");
    run("3x-5", 32'd3, -32'sd5, 1'b1);
    check("3x-5_const", result, 64'hFFFF_FFFF_FFFF_FFF1);
    clear_op("3x-5");

    // asynchronous reset mid-EXEC, sampled between edges
    start_op(32'h1234_5678, 32'h9ABC_DEF1);
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("async_reset_done", 64'(op_done), 64'd0);
    check("async_reset_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    watch_idle("async_reset");
    run("after_reset", 32'd100, -32'sd3, 1'b1);
    clear_op("after_reset");

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom();
      if (i % 10 == 0) ra = 32'(-$signed(32'($urandom_range(0, 15))));
      run($sformatf("rand%0d", i), ra, rb, 1'b1);
      op_clear = 1'b1;
      tick();
      op_clear = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
